strobe_accum_dump: RTL and testbench

Integrate-and-dump decimator that sits directly downstream of the two-input add-and-clip register stage. It accumulates 2^log2_rate strobed signed samples and emits one scaled, rounded and clipped result per block with a single-cycle output strobe. It reduces sample rate ahead of slower consumers while keeping the strobe-qualified data convention of the adder stage.

---
 rtl/strobe_accum_dump_pkg.sv | 24 ++
 rtl/round_shift_clip.sv | 48 ++++
 rtl/strobe_accum_dump.sv | 125 ++++++++++++
 tb/tb_strobe_accum_dump.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/strobe_accum_dump_pkg.sv
// strobe_accum_dump_pkg
//   Shared types and constants for the integrate-and-dump decimator and the
//   rounding/clipping stage it feeds.
//   - state_e  : block fill state (EMPTY / FILL)
//   - ACC_W    : accumulator width for the default configuration
//   - sat_ctrl : saturates a 4-bit control field to a maximum value
package strobe_accum_dump_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FILL  = 1'b1
    } state_e;

    localparam int WIDTH_DEF     = 16;
    localparam int MAX_LOG2_DEF  = 8;
    localparam int ACC_W         = WIDTH_DEF + MAX_LOG2_DEF;
    localparam int CTRL_W        = 4;

    function automatic logic [CTRL_W-1:0] sat_ctrl(input logic [CTRL_W-1:0] v,
                                                   input logic [CTRL_W-1:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/round_shift_clip.sv
// round_shift_clip
//   Combinational round-half-up arithmetic right shift followed by a clip to a
//   narrower signed width.
//   acc_i   : signed accumulator value (IN_W)
//   shift_i : right-shift amount (SH_W), caller keeps it within range
//   res_o   : clip((acc_i + half) >>> shift_i) (OUT_W)
//   clip_o  : 1 when the clip changed the value
module round_shift_clip #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 16,
    parameter int SH_W  = 4
) (
    input  logic signed [IN_W-1:0]  acc_i,
    input  logic        [SH_W-1:0]  shift_i,
    output logic signed [OUT_W-1:0] res_o,
    output logic                    clip_o
);

    // One guard bit so adding the rounding bias can never wrap.
    localparam int EXT_W = IN_W + 1;
    localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
    localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] bias;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] shd;

    always_comb begin
        ext  = {acc_i[IN_W-1], acc_i};
        bias = '0;
        if (shift_i != '0) begin
            bias = EXT_W'(1) << (shift_i - SH_W'(1));
        end
        rnd    = ext + bias;
        shd    = rnd >>> shift_i;
        res_o  = shd[OUT_W-1:0];
        clip_o = 1'b0;
        if (shd > MAX_V) begin
            res_o  = MAX_V[OUT_W-1:0];
            clip_o = 1'b1;
        end else if (shd < MIN_V) begin
            res_o  = MIN_V[OUT_W-1:0];
            clip_o = 1'b1;
        end
    end

endmodule

// File: rtl/strobe_accum_dump.sv
// strobe_accum_dump
//   Integrate-and-dump decimator: sums 2^log2_rate strobed signed samples,
//   then emits one rounded, shifted and clipped result with a 1-cycle strobe.
//   clk, rst_n     : clock, synchronous active-low reset
//   log2_rate      : block length exponent (saturated to MAX_LOG2_RATE)
//   shift          : right shift applied to the block sum (saturated)
//   in, strobe_in  : sample and its qualifier
//   out, clipped   : registered result and saturation flag, held between dumps
//   strobe_out     : one-cycle pulse when out carries a new result
module strobe_accum_dump
    import strobe_accum_dump_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int MAX_LOG2_RATE = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CTRL_W-1:0]       log2_rate,
    input  logic [CTRL_W-1:0]       shift,
    input  logic signed [WIDTH-1:0] in,
    input  logic                    strobe_in,
    output logic signed [WIDTH-1:0] out,
    output logic                    strobe_out,
    output logic                    clipped
);

    localparam int AW    = WIDTH + MAX_LOG2_RATE;
    localparam int CNT_W = MAX_LOG2_RATE + 1;   // must hold N = 2^MAX_LOG2_RATE
    localparam logic [CTRL_W-1:0] MAX_CTRL = CTRL_W'(MAX_LOG2_RATE);

    state_e                  state_q, state_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CTRL_W-1:0]       rate_q, rate_d;
    logic [CTRL_W-1:0]       shift_q, shift_d;
    logic signed [WIDTH-1:0] out_q, out_d;
    logic                    clipped_q, clipped_d;
    logic                    strobe_q, strobe_d;

    logic signed [AW-1:0]    in_ext;
    logic signed [AW-1:0]    sum;
    logic [CNT_W-1:0]        cnt_inc;
    logic [CNT_W-1:0]        blk_len;
    logic [CTRL_W-1:0]       eff_rate;
    logic [CTRL_W-1:0]       eff_shift;
    logic                    last;
    logic signed [WIDTH-1:0] rsc_res;
    logic                    rsc_clip;

    // The sample that opens a block uses the live controls (so N=1 can dump
    // straight away); every later sample in the block uses the latched copy.
    always_comb begin
        in_ext    = {{MAX_LOG2_RATE{in[WIDTH-1]}}, in};
        eff_rate  = (state_q == EMPTY) ? sat_ctrl(log2_rate, MAX_CTRL) : rate_q;
        eff_shift = (state_q == EMPTY) ? sat_ctrl(shift, MAX_CTRL)     : shift_q;
        sum       = (state_q == EMPTY) ? in_ext : acc_q + in_ext;
        cnt_inc   = (state_q == EMPTY) ? CNT_W'(1) : cnt_q + CNT_W'(1);
        blk_len   = CNT_W'(1) << eff_rate;
        last      = (cnt_inc == blk_len);
    end

    round_shift_clip #(
        .IN_W  (AW),
        .OUT_W (WIDTH),
        .SH_W  (CTRL_W)
    ) u_rsc (
        .acc_i   (sum),
        .shift_i (eff_shift),
        .res_o   (rsc_res),
        .clip_o  (rsc_clip)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        rate_d    = rate_q;
        shift_d   = shift_q;
        out_d     = out_q;
        clipped_d = clipped_q;
        strobe_d  = 1'b0;
        if (strobe_in) begin
            acc_d   = sum;
            rate_d  = eff_rate;
            shift_d = eff_shift;
            if (last) begin
                state_d   = EMPTY;
                cnt_d     = '0;
                out_d     = rsc_res;
                clipped_d = rsc_clip;
                strobe_d  = 1'b1;
            end else begin
                state_d = FILL;
                cnt_d   = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            acc_q     <= '0;
            cnt_q     <= '0;
            rate_q    <= '0;
            shift_q   <= '0;
            out_q     <= '0;
            clipped_q <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            rate_q    <= rate_d;
            shift_q   <= shift_d;
            out_q     <= out_d;
            clipped_q <= clipped_d;
            strobe_q  <= strobe_d;
        end
    end

    assign out        = out_q;
    assign clipped    = clipped_q;
    assign strobe_out = strobe_q;

endmodule

// File: tb/tb_strobe_accum_dump.sv
module tb_strobe_accum_dump;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0]        log2_rate = 4'd2;
    logic [3:0]        shift = 4'd2;
    logic signed [15:0] din = '0;
    logic              strobe_in = 1'b0;
    logic signed [15:0] dout;
    logic              strobe_out;
    logic              clipped;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        logic signed [15:0] v;
        logic               c;
        int                 cyc;
    } exp_t;

    exp_t sb[$];

    strobe_accum_dump #(.WIDTH(16), .MAX_LOG2_RATE(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .log2_rate  (log2_rate),
        .shift      (shift),
        .in         (din),
        .strobe_in  (strobe_in),
        .out        (dout),
        .strobe_out (strobe_out),
        .clipped    (clipped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every strobe_out must match the oldest pending result.
    always @(negedge clk) begin
        if (strobe_out) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe_out", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out", int'(dout), int'(e.v));
                check("clipped", int'(clipped), int'(e.c));
                check("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    // Present one strobed sample for one edge; optionally expect a dump from it.
    task automatic smp(input int v, input bit dump, input int ev, input bit ec);
        exp_t e;
        din       = 16'(v);
        strobe_in = 1'b1;
        if (dump) begin
            e.v   = 16'(ev);
            e.c   = ec;
            e.cyc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        strobe_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle(3);
        check("reset_out", int'(dout), 0);
        check("reset_clipped", int'(clipped), 0);
        check("reset_strobe_out", int'(strobe_out), 0);
        rst_n = 1'b1;
        idle(1);

        // N=4, shift 2: (406+2)>>2 = 102
        log2_rate = 4'd2; shift = 4'd2;
        smp(100, 0, 0, 0); smp(101, 0, 0, 0); smp(102, 0, 0, 0); smp(103, 1, 102, 0);
        idle(2);

        // Positive and negative clipping, back-to-back blocks
        shift = 4'd0;
        smp(32767, 0, 0, 0); smp(32767, 0, 0, 0); smp(32767, 0, 0, 0); smp(32767, 1, 32767, 1);
        smp(-32768, 0, 0, 0); smp(-32768, 0, 0, 0); smp(-32768, 0, 0, 0); smp(-32768, 1, -32768, 1);
        idle(2);

        // Negative sum rounding: (-5+2)>>>2 = -1
        shift = 4'd2;
        smp(-1, 0, 0, 0); smp(-1, 0, 0, 0); smp(-1, 0, 0, 0); smp(-2, 1, -1, 0);
        idle(2);

        // N=1 pass-through with gaps
        log2_rate = 4'd0; shift = 4'd0;
        smp(5, 1, 5, 0); idle(2);
        smp(-7, 1, -7, 0); idle(1);
        smp(9, 1, 9, 0);
        idle(2);

        // N=1 with shift 1: (3+1)>>1 = 2, (-3+1)>>>1 = -1
        shift = 4'd1;
        smp(3, 1, 2, 0); smp(-3, 1, -1, 0);
        idle(2);

        // Rate change mid-block only takes effect on the next block
        log2_rate = 4'd2; shift = 4'd0;
        smp(1, 0, 0, 0); smp(2, 0, 0, 0);
        log2_rate = 4'd3;
        smp(3, 0, 0, 0); smp(4, 1, 10, 0);
        for (int i = 1; i <= 8; i++) smp(i, (i == 8), 36, 0);
        idle(2);

        // Saturated controls: N=256, shift 8: (25600+128)>>8 = 100
        log2_rate = 4'd15; shift = 4'd15;
        for (int i = 1; i <= 256; i++) smp(100, (i == 256), 100, 0);
        idle(2);

        // Reset mid-block discards the partial block
        log2_rate = 4'd2; shift = 4'd2;
        smp(50, 0, 0, 0); smp(50, 0, 0, 0); smp(50, 0, 0, 0);
        rst_n = 1'b0; idle(1); rst_n = 1'b1;
        smp(8, 0, 0, 0); smp(8, 0, 0, 0); smp(8, 0, 0, 0); smp(8, 1, 8, 0);
        idle(2);

        // Reset coincident with the final strobe wins
        smp(8, 0, 0, 0); smp(8, 0, 0, 0); smp(8, 0, 0, 0);
        rst_n = 1'b0;
        smp(8, 0, 0, 0);
        rst_n = 1'b1;
        idle(1);
        check("reset_final_out", int'(dout), 0);
        check("reset_final_clipped", int'(clipped), 0);
        idle(3);

        check("pending_results", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
